// File: rtl/mod_ser16_if.sv
// rtl/mod_ser16_if.sv - block-in / byte-out stream bundle for mod_ser16
interface mod_ser16_if #(parameter int N = 16) ();
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0][7:0] i;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        o;
  logic              out_last;

  modport slave (
    input  in_valid, i, out_ready,
    output in_ready, out_valid, o, out_last
  );

  modport master (
    output in_valid, i, out_ready,
    input  in_ready, out_valid, o, out_last
  );
endinterface

// File: rtl/mod_ser16.sv
// rtl/mod_ser16.sv - N-byte block to byte-stream serializer with zero-bubble reload
module mod_ser16 #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         resetn,
  mod_ser16_if.slave   bus,
  output logic         busy
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IW-1:0]     idx;
  logic [N-1:0][7:0] buf_q;
  logic [7:0]        o_q;
  logic              at_last;
  logic              xfer;
  logic              accept;
  logic              rdy;

  always_comb begin
    at_last   = (state == SEND) && (idx == LAST_IDX);
    xfer      = (state == SEND) && bus.out_ready;
    rdy       = (state == IDLE) || (at_last && bus.out_ready);
    accept    = bus.in_valid && rdy;
    state_nxt = state;
    // a new block wins over the return to IDLE so reload has no bubble
    if (accept) begin
      state_nxt = SEND;
    end else if (xfer && at_last) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx   <= '0;
      buf_q <= '0;
      o_q   <= 8'h00;
    end else if (accept) begin
      buf_q <= bus.i;
      idx   <= '0;
      o_q   <= bus.i[0];
    end else if (xfer && !at_last) begin
      idx   <= idx + IW'(1);
      o_q   <= buf_q[idx + IW'(1)];
    end else if (xfer) begin
      // o keeps the final byte while idle; downstream ignores it
      idx   <= '0;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = (state == SEND);
  assign bus.out_last  = at_last;
  assign bus.o         = o_q;
  assign busy          = (state == SEND);
endmodule

// File: tb/tb_mod_ser16.sv
// tb/tb_mod_ser16.sv - self-checking bench for mod_ser16 against a byte-queue model
module tb_mod_ser16;
  localparam int N = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;

  mod_ser16_if #(.N(N)) bus ();

  mod_ser16 #(.N(N)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q[$];
  logic [7:0] got[$];
  int         stamp[$];
  int         acc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model: remaining bytes of the held block, front = byte on o
  always @(negedge clk) begin
    logic m_ready;
    if (!resetn) q.delete();
    chk("out_valid", bus.out_valid, q.size() > 0);
    chk("busy", busy, q.size() > 0);
    m_ready = (q.size() == 0) || (q.size() == 1 && bus.out_ready);
    chk("in_ready", bus.in_ready, m_ready);
    if (q.size() > 0) begin
      chk("o", bus.o, q[0]);
      chk("out_last", bus.out_last, q.size() == 1);
    end
    if (resetn) begin
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(bus.o);
        stamp.push_back(cyc);
      end
      if (bus.in_valid && bus.in_ready) acc.push_back(cyc);
      if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && m_ready)
        for (int k = 0; k < N; k++) q.push_back(bus.i[k]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] base);
    for (int k = 0; k < N; k++) bus.i[k] = 8'(base + 8'(k));
  endtask

  task automatic wait_accept(input int budget);
    bit done = 0;
    for (int n = 0; n < budget && !done; n++) begin
      if (bus.in_ready) done = 1;
      step();
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain(input int cycles);
    for (int n = 0; n < cycles; n++) step();
  endtask

  task automatic check_seq(input string name, input int from, input logic [7:0] base, input int cnt);
    for (int k = 0; k < cnt; k++)
      if (from + k < got.size()) chk(name, got[from + k], 8'(base + 8'(k)));
      else chk({name, "_missing"}, from + k, got.size());
  endtask

  task automatic clear_logs();
    got.delete();
    stamp.delete();
    acc.delete();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.i         = '0;
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_o", bus.o, 8'h00);
    chk("rst_in_ready", bus.in_ready, 1);
    step();
    resetn = 1'b1;

    // idle hold
    for (int n = 0; n < 10; n++) begin
      step();
      chk("idle_out_valid", bus.out_valid, 0);
      chk("idle_in_ready", bus.in_ready, 1);
    end

    // single block, out_ready held high
    clear_logs();
    bus.out_ready = 1'b1;
    load(8'h00);
    bus.in_valid = 1'b1;
    wait_accept(5);
    bus.in_valid = 1'b0;
    drain(20);
    chk("single_count", got.size(), 16);
    check_seq("single_seq", 0, 8'h00, 16);
    if (acc.size() > 0 && stamp.size() == 16) begin
      chk("single_latency", stamp[0] - acc[0], 1);
      chk("single_span", stamp[15] - stamp[0], 15);
    end else chk("single_logs", acc.size(), 1);
    chk("single_end_valid", bus.out_valid, 0);

    // backpressure 1,0,0,1 ...
    clear_logs();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    wait_accept(5);
    bus.in_valid = 1'b0;
    for (int n = 0; n < 70; n++) begin
      bus.out_ready = (n % 4 == 0) || (n % 4 == 3);
      step();
    end
    bus.out_ready = 1'b1;
    drain(3);
    chk("bp_count", got.size(), 16);
    check_seq("bp_seq", 0, 8'h00, 16);

    // back-to-back A then B
    clear_logs();
    load(8'hA0);
    bus.in_valid = 1'b1;
    wait_accept(5);
    load(8'hB0);
    wait_accept(20);
    bus.in_valid = 1'b0;
    drain(20);
    chk("b2b_count", got.size(), 32);
    check_seq("b2b_seq", 0, 8'hA0, 16);
    check_seq("b2b_seq", 16, 8'hB0, 16);
    if (stamp.size() == 32 && acc.size() == 2) begin
      chk("b2b_span", stamp[31] - stamp[0], 31);
      chk("b2b_accept_at_af", acc[1], stamp[15]);
    end else chk("b2b_logs", acc.size(), 2);

    // ignored input while streaming
    clear_logs();
    load(8'hA0);
    bus.in_valid = 1'b1;
    wait_accept(5);
    bus.i = {N{8'hFF}};
    drain(8);
    bus.in_valid = 1'b0;
    drain(15);
    chk("ign_count", got.size(), 16);
    check_seq("ign_seq", 0, 8'hA0, 16);
    foreach (got[k]) if (got[k] == 8'hFF) chk("ign_no_ff", got[k], 0);

    // async reset mid-stream after byte 0x05
    clear_logs();
    load(8'h00);
    bus.in_valid = 1'b1;
    wait_accept(5);
    bus.in_valid = 1'b0;
    for (int n = 0; n < 20 && got.size() < 6; n++) step();
    chk("pre_rst_count", got.size(), 6);
    step();
    #1;
    resetn = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_o", bus.o, 8'h00);
    chk("mid_rst_busy", busy, 0);
    step();
    resetn = 1'b1;
    clear_logs();
    chk("post_rst_in_ready", bus.in_ready, 1);
    load(8'h10);
    bus.in_valid = 1'b1;
    wait_accept(2);
    bus.in_valid = 1'b0;
    drain(20);
    chk("post_rst_count", got.size(), 16);
    check_seq("post_rst_seq", 0, 8'h10, 16);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1);
  end
endmodule
